// File: rtl/d_hazard_unit.sv
// d_hazard_unit: D-stage stall and operand-forwarding control.
// Shadows the E/M/W destinations and the time until their results exist.
module d_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             d_valid,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_rs_tuse,
  input  logic [1:0]       d_rt_tuse,
  input  logic [4:0]       d_dst,
  input  logic [1:0]       d_tnew,
  input  logic [31:0]      rf_rd1,
  input  logic [31:0]      rf_rd2,
  input  logic [31:0]      e_data,
  input  logic [31:0]      m_data,
  input  logic [31:0]      w_data,
  output logic             stall,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rt,
  output logic [31:0]      cmp1,
  output logic [31:0]      cmp2,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_W  = 2'd1;
  localparam logic [1:0] SEL_M  = 2'd2;
  localparam logic [1:0] SEL_E  = 2'd3;
  localparam logic [1:0] TU_NONE = 2'd3;

  logic [4:0]       r_e_dst;
  logic [1:0]       r_e_tnew;
  logic [4:0]       r_m_dst;
  logic [1:0]       r_m_tnew;
  logic [4:0]       r_w_dst;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_haz_rs;
  logic             w_haz_rt;
  logic             w_stall;
  logic             w_issue;
  logic             w_cnt_full;
  logic [1:0]       w_m_tnew_nxt;
  logic [1:0]       w_fwd_rs;
  logic [1:0]       w_fwd_rt;
  logic [31:0]      w_cmp1;
  logic [31:0]      w_cmp2;

  function automatic logic f_hazard(
    input logic [4:0] s,
    input logic [1:0] tuse,
    input logic [4:0] e_dst,
    input logic [1:0] e_tnew,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew
  );
    logic live;
    logic e_hit;
    logic m_hit;
    live  = (s != 5'd0) && (tuse != TU_NONE);
    e_hit = (e_dst == s) && (e_tnew > tuse);
    m_hit = (m_dst == s) && (m_tnew > tuse);
    return live && (e_hit || m_hit);
  endfunction

  // Youngest ready producer wins; a not-yet-ready match falls through.
  function automatic logic [1:0] f_fwd(
    input logic [4:0] s,
    input logic [4:0] e_dst,
    input logic [1:0] e_tnew,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew,
    input logic [4:0] w_dst
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (s == 5'd0)
      sel = SEL_RF;
    else if ((e_dst == s) && (e_tnew == 2'd0))
      sel = SEL_E;
    else if ((m_dst == s) && (m_tnew == 2'd0))
      sel = SEL_M;
    else if (w_dst == s)
      sel = SEL_W;
    return sel;
  endfunction

  function automatic logic [31:0] f_mux(
    input logic [4:0]  s,
    input logic [1:0]  sel,
    input logic [31:0] rf,
    input logic [31:0] wd,
    input logic [31:0] md,
    input logic [31:0] ed
  );
    logic [31:0] v;
    v = 32'h0;
    if (s != 5'd0) begin
      unique case (sel)
        SEL_RF: v = rf;
        SEL_W:  v = wd;
        SEL_M:  v = md;
        SEL_E:  v = ed;
      endcase
    end
    return v;
  endfunction

  always_comb begin
    w_haz_rs = f_hazard(d_rs, d_rs_tuse,
                        r_e_dst, r_e_tnew,
                        r_m_dst, r_m_tnew);
    w_haz_rt = f_hazard(d_rt, d_rt_tuse,
                        r_e_dst, r_e_tnew,
                        r_m_dst, r_m_tnew);
    w_stall  = reset_n & d_valid
             & (w_haz_rs | w_haz_rt);
    w_issue  = d_valid & ~w_stall;
  end

  always_comb begin
    w_fwd_rs = f_fwd(d_rs, r_e_dst, r_e_tnew,
                     r_m_dst, r_m_tnew, r_w_dst);
    w_fwd_rt = f_fwd(d_rt, r_e_dst, r_e_tnew,
                     r_m_dst, r_m_tnew, r_w_dst);
    w_cmp1   = f_mux(d_rs, w_fwd_rs, rf_rd1,
                     w_data, m_data, e_data);
    w_cmp2   = f_mux(d_rt, w_fwd_rt, rf_rd2,
                     w_data, m_data, e_data);
  end

  always_comb begin
    w_m_tnew_nxt = 2'd0;
    if (r_e_tnew != 2'd0)
      w_m_tnew_nxt = r_e_tnew - 2'd1;
    w_cnt_full = &r_stall_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e_dst  <= 5'd0;
      r_e_tnew <= 2'd0;
      r_m_dst  <= 5'd0;
      r_m_tnew <= 2'd0;
      r_w_dst  <= 5'd0;
    end else begin
      r_e_dst  <= w_issue ? d_dst  : 5'd0;
      r_e_tnew <= w_issue ? d_tnew : 2'd0;
      r_m_dst  <= r_e_dst;
      r_m_tnew <= w_m_tnew_nxt;
      r_w_dst  <= r_m_dst;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stall_cnt <= '0;
    else if (w_stall && !w_cnt_full)
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
  end

  assign stall     = w_stall;
  assign fwd_rs    = w_fwd_rs;
  assign fwd_rt    = w_fwd_rt;
  assign cmp1      = w_cmp1;
  assign cmp2      = w_cmp2;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_d_hazard_unit.sv
// tb_d_hazard_unit: vector table, directed corner sequences and
// randomized traffic against an age-based producer model.
module tb_d_hazard_unit;

  localparam logic [31:0] RF1 = 32'h1111_1111;
  localparam logic [31:0] RF2 = 32'h2222_2222;
  localparam logic [31:0] WD  = 32'h3333_3333;
  localparam logic [31:0] MD  = 32'h4444_4444;
  localparam logic [31:0] ED  = 32'h5555_5555;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        d_valid;
  logic [4:0]  d_rs, d_rt, d_dst;
  logic [1:0]  d_rs_tuse, d_rt_tuse, d_tnew;
  logic [31:0] rf_rd1, rf_rd2, e_data, m_data, w_data;

  logic        stall, stall2;
  logic [1:0]  fwd_rs, fwd_rt, fwd_rs2, fwd_rt2;
  logic [31:0] cmp1, cmp2, cmp1_2, cmp2_2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  d_hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_dst(d_dst), .d_tnew(d_tnew),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .e_data(e_data), .m_data(m_data), .w_data(w_data),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .cmp1(cmp1), .cmp2(cmp2), .stall_cnt(stall_cnt)
  );

  d_hazard_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_dst(d_dst), .d_tnew(d_tnew),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .e_data(e_data), .m_data(m_data), .w_data(w_data),
    .stall(stall2), .fwd_rs(fwd_rs2), .fwd_rt(fwd_rt2),
    .cmp1(cmp1_2), .cmp2(cmp2_2), .stall_cnt(stall_cnt2)
  );

  // Model: instructions indexed by age since E entry (0=E,1=M,2=W),
  // each keeping the tnew it had when it entered E.
  logic [4:0] a_dst [3];
  logic [1:0] a_tn  [3];
  int m_cnt16;
  int m_cnt2;

  function automatic int m_rem(int age);
    int t;
    t = int'(a_tn[age]);
    return (t > age) ? t - age : 0;
  endfunction

  function automatic bit m_haz(logic [4:0] s, logic [1:0] tu);
    bit h;
    h = 0;
    if (s != 0 && tu != 3)
      for (int age = 0; age < 2; age++)
        if (a_dst[age] == s && m_rem(age) > int'(tu)) h = 1;
    return h;
  endfunction

  function automatic bit m_stall();
    return reset_n && d_valid &&
           (m_haz(d_rs, d_rs_tuse) || m_haz(d_rt, d_rt_tuse));
  endfunction

  function automatic logic [1:0] m_sel(logic [4:0] s);
    if (s == 0) return 2'd0;
    for (int age = 0; age < 3; age++)
      if (a_dst[age] == s && m_rem(age) == 0)
        return 2'(3 - age);
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_val(logic [4:0] s,
                                        logic [1:0] sel,
                                        logic [31:0] rf);
    if (s == 0) return 32'h0;
    case (sel)
      2'd1:    return w_data;
      2'd2:    return m_data;
      2'd3:    return e_data;
      default: return rf;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        a_dst[i] <= 5'd0;
        a_tn[i]  <= 2'd0;
      end
      m_cnt16 <= 0;
      m_cnt2  <= 0;
    end else begin
      a_dst[2] <= a_dst[1];
      a_tn[2]  <= a_tn[1];
      a_dst[1] <= a_dst[0];
      a_tn[1]  <= a_tn[0];
      a_dst[0] <= (d_valid && !m_stall()) ? d_dst : 5'd0;
      a_tn[0]  <= (d_valid && !m_stall()) ? d_tnew : 2'd0;
      if (m_stall()) begin
        m_cnt16 <= (m_cnt16 == 65535) ? m_cnt16 : m_cnt16 + 1;
        m_cnt2  <= (m_cnt2 == 3) ? m_cnt2 : m_cnt2 + 1;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    logic [1:0] s1, s2;
    bit st;
    st = m_stall();
    chk({tag, ".stall"}, 32'(stall), 32'(st));
    chk({tag, ".stall2"}, 32'(stall2), 32'(st));
    chk({tag, ".cnt"}, 32'(stall_cnt), 32'(m_cnt16));
    chk({tag, ".cnt2"}, 32'(stall_cnt2), 32'(m_cnt2));
    if (!st) begin
      s1 = m_sel(d_rs);
      s2 = m_sel(d_rt);
      chk({tag, ".fwd_rs"}, 32'(fwd_rs), 32'(s1));
      chk({tag, ".fwd_rt"}, 32'(fwd_rt), 32'(s2));
      chk({tag, ".cmp1"}, cmp1, m_val(d_rs, s1, rf_rd1));
      chk({tag, ".cmp2"}, cmp2, m_val(d_rt, s2, rf_rd2));
    end
  endtask

  task automatic drive(logic v, logic [4:0] rs, logic [1:0] rst,
                       logic [4:0] rt, logic [1:0] rtt,
                       logic [4:0] dst, logic [1:0] tn);
    d_valid = v;   d_rs = rs; d_rs_tuse = rst;
    d_rt = rt;     d_rt_tuse = rtt;
    d_dst = dst;   d_tnew = tn;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic fixed_buses();
    rf_rd1 = RF1; rf_rd2 = RF2;
    w_data = WD;  m_data = MD; e_data = ED;
  endtask

  typedef struct {
    logic [4:0]  p_dst;
    logic [1:0]  p_tn;
    int          gap;
    logic [4:0]  rs;
    logic [1:0]  rs_tu;
    logic [4:0]  rt;
    logic [1:0]  rt_tu;
    logic        x_st;
    logic [1:0]  x_frs;
    logic [1:0]  x_frt;
    logic [31:0] x_c1;
    logic [31:0] x_c2;
  } vec_t;

  vec_t tbl [13];
  int   sat_exp [5];

  initial begin
    tbl[0]  = '{5, 2, 0, 5, 0, 0, 3, 1, 0, 0, RF1, 0};
    tbl[1]  = '{5, 2, 1, 5, 0, 0, 3, 1, 0, 0, RF1, 0};
    tbl[2]  = '{5, 2, 1, 5, 1, 0, 3, 0, 0, 0, RF1, 0};
    tbl[3]  = '{5, 2, 2, 5, 0, 0, 3, 0, 1, 0, WD, 0};
    tbl[4]  = '{3, 1, 0, 3, 0, 3, 0, 1, 0, 0, RF1, 0};
    tbl[5]  = '{3, 1, 1, 3, 0, 3, 0, 0, 2, 2, MD, MD};
    tbl[6]  = '{3, 0, 0, 3, 0, 3, 2, 0, 3, 3, ED, ED};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{5, 2, 0, 5, 3, 6, 0, 0, 0, 0, RF1, RF2};
    tbl[9]  = '{5, 2, 3, 5, 0, 0, 3, 0, 0, 0, RF1, 0};
    tbl[10] = '{3, 1, 0, 3, 1, 0, 3, 0, 0, 0, RF1, 0};
    tbl[11] = '{4, 2, 0, 4, 2, 0, 3, 0, 0, 0, RF1, 0};
    tbl[12] = '{7, 0, 0, 0, 0, 7, 0, 0, 0, 3, 0, ED};
    sat_exp = '{1, 2, 3, 3, 3};

    fixed_buses();
    idle();
    d_rs = 5'd5;
    reset_n = 1'b0;
    #12;
    chk("rst.stall", 32'(stall), 0);
    chk("rst.cnt", 32'(stall_cnt), 0);
    chk("rst.fwd_rs", 32'(fwd_rs), 0);
    chk("rst.cmp1", cmp1, RF1);
    chk("rst.cmp2", cmp2, 32'h0);
    step();
    reset_n = 1'b1;

    // Vector table: producer, gap of bubbles, then consumer.
    foreach (tbl[i]) begin
      idle();
      repeat (3) step();
      drive(1'b1, 0, 3, 0, 3, tbl[i].p_dst, tbl[i].p_tn);
      step();
      idle();
      repeat (tbl[i].gap) step();
      drive(1'b1, tbl[i].rs, tbl[i].rs_tu,
            tbl[i].rt, tbl[i].rt_tu, 5'd0, 2'd0);
      @(negedge clk);
      chk($sformatf("vec%0d.stall", i), 32'(stall),
          32'(tbl[i].x_st));
      if (!tbl[i].x_st) begin
        chk($sformatf("vec%0d.fwd_rs", i), 32'(fwd_rs),
            32'(tbl[i].x_frs));
        chk($sformatf("vec%0d.fwd_rt", i), 32'(fwd_rt),
            32'(tbl[i].x_frt));
        chk($sformatf("vec%0d.cmp1", i), cmp1, tbl[i].x_c1);
        chk($sformatf("vec%0d.cmp2", i), cmp2, tbl[i].x_c2);
      end
      check_model($sformatf("vec%0d.m", i));
      step();
    end

    // Load-use: two stall cycles, then W forward.
    idle();
    do_reset();
    drive(1'b1, 0, 3, 0, 3, 5, 2);
    step();
    drive(1'b1, 5, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("lu.stall", 32'(stall), 1);
      step();
    end
    @(negedge clk);
    chk("lu.stall_end", 32'(stall), 0);
    chk("lu.fwd_rs", 32'(fwd_rs), 1);
    chk("lu.cmp1", cmp1, WD);
    chk("lu.cnt", 32'(stall_cnt), 2);
    step();

    // ALU result: one stall, then M forward on both sources.
    idle();
    do_reset();
    m_data = 32'h0000_00AB;
    drive(1'b1, 0, 3, 0, 3, 3, 1);
    step();
    drive(1'b1, 3, 0, 3, 0, 0, 0);
    @(negedge clk);
    chk("alu.stall", 32'(stall), 1);
    step();
    @(negedge clk);
    chk("alu.stall_end", 32'(stall), 0);
    chk("alu.fwd_rs", 32'(fwd_rs), 2);
    chk("alu.fwd_rt", 32'(fwd_rt), 2);
    chk("alu.cmp1", cmp1, 32'h0000_00AB);
    chk("alu.cmp2", cmp2, 32'h0000_00AB);
    step();

    // Register zero in E, beq $0,$0.
    idle();
    drive(1'b1, 0, 3, 0, 3, 0, 0);
    step();
    drive(1'b1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero.stall", 32'(stall), 0);
    chk("zero.fwd_rs", 32'(fwd_rs), 0);
    chk("zero.fwd_rt", 32'(fwd_rt), 0);
    chk("zero.cmp1", cmp1, 32'h0);
    chk("zero.cmp2", cmp2, 32'h0);
    step();

    // Same register ready in both E and M: E wins.
    e_data = 32'h1;
    m_data = 32'h2;
    drive(1'b1, 0, 3, 0, 3, 7, 0);
    step();
    step();
    drive(1'b1, 7, 0, 0, 3, 0, 0);
    @(negedge clk);
    chk("prio.fwd_rs", 32'(fwd_rs), 3);
    chk("prio.cmp1", cmp1, 32'h1);
    check_model("prio.m");
    step();
    fixed_buses();

    // Saturation of the 2-bit counter over five stall cycles.
    idle();
    do_reset();
    drive(1'b1, 0, 3, 0, 3, 5, 2);
    step();
    begin
      int k;
      k = 0;
      for (int c = 0; c < 3; c++) begin
        drive(1'b1, 5'(5 + c), 0, 0, 3,
              (c < 2) ? 5'(6 + c) : 5'd0, 2);
        for (int s = 0; s < ((c < 2) ? 2 : 1); s++) begin
          @(negedge clk);
          chk("sat.stall", 32'(stall), 1);
          step();
          chk($sformatf("sat.cnt%0d", k), 32'(stall_cnt2),
              32'(sat_exp[k]));
          k++;
        end
        if (c < 2) step();
      end
    end
    chk("sat.cnt16", 32'(stall_cnt), 5);

    // Asynchronous reset in the middle of a stall.
    idle();
    do_reset();
    drive(1'b1, 0, 3, 0, 3, 5, 2);
    step();
    drive(1'b1, 5, 0, 0, 3, 0, 0);
    @(negedge clk);
    chk("ars.stall_pre", 32'(stall), 1);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("ars.stall", 32'(stall), 0);
    chk("ars.cnt", 32'(stall_cnt), 0);
    chk("ars.fwd_rs", 32'(fwd_rs), 0);
    chk("ars.cmp1", cmp1, RF1);
    check_model("ars.m");
    step();
    reset_n = 1'b1;
    drive(1'b1, 5, 0, 0, 3, 9, 2);
    @(negedge clk);
    chk("ars.cleared", 32'(stall), 0);
    step();
    drive(1'b1, 9, 0, 0, 3, 0, 0);
    @(negedge clk);
    chk("ars.first_edge", 32'(stall), 1);
    step();

    // Randomized traffic against the model.
    idle();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 9) < 8),
            5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
      rf_rd1 = $urandom; rf_rd2 = $urandom;
      e_data = $urandom; m_data = $urandom; w_data = $urandom;
      @(negedge clk);
      check_model($sformatf("rnd%0d", n));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/d_hazard_unit.md
D_HAZARD_UNIT -- requirements
Module: d_hazard_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-002 clk  in  1  the single clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  reset, asynchronous and active-low; the block is in reset while reset_n=0.
REQ-004 d_valid  in  1  D stage holds a real instruction.
REQ-005 d_rs, d_rt  in  5 each  D-stage source register indices.
REQ-006 d_rs_tuse, d_rt_tuse  in  2 each  cycles until the operand is consumed: 0..2; 3 = operand unused.
REQ-007 d_dst  in  5  D-stage destination register; 0 = no write.
REQ-008 d_tnew  in  2  cycles after E entry until the result exists: 0..2.
REQ-009 rf_rd1, rf_rd2  in  32 each  register-file read data for d_rs and d_rt.
REQ-010 e_data, m_data, w_data  in  32 each  result buses of the E, M and W stages.
REQ-011 stall  out  1  freezes PC and the D register, and inserts a bubble into E.
REQ-012 fwd_rs, fwd_rt  out  2 each  operand source select: 0=RF, 1=W, 2=M, 3=E.
REQ-013 cmp1, cmp2  out  32 each  forwarded rs and rt values, fed to the D-stage equality comparator.
REQ-014 stall_cnt  out  CNT_W  total count of cycles with stall=1.

Function
REQ-015 The block SHALL keep a shadow pipeline of three slots, E{dst,tnew}, M{dst,tnew} and W{dst}, that mirrors the downstream stages.
REQ-016 On each clock edge with stall=0 and d_valid=1: E<={d_dst,d_tnew}.
REQ-017 On each clock edge with stall=1 or d_valid=0: E<={0,0}, i.e. a bubble.
REQ-018 On every clock edge: M<={E.dst, sat(E.tnew-1)} and W<={M.dst}, where sat() floors the result at 0.
REQ-019 Source s is a hazard source if its index is nonzero and its tuse is not 3.
REQ-020 stall SHALL be 1 if, for any hazard source s, (E.dst==s and E.tnew>tuse_s) or (M.dst==s and M.tnew>tuse_s); otherwise stall SHALL be 0.
REQ-021 stall SHALL be combinational from the current slots and the D inputs, with zero cycles of latency.
REQ-022 stall SHALL be 0 whenever d_valid=0.
REQ-023 The forward select for source s SHALL take the first match in this priority order:
- E.dst==s, s!=0 and E.tnew==0 -> 3
- M.dst==s, s!=0 and M.tnew==0 -> 2
- W.dst==s and s!=0 -> 1
- otherwise -> 0
REQ-024 cmp1 and cmp2 SHALL be the selected bus values; when the index is 0 the output SHALL be 32'h0, regardless of the select.
REQ-025 A slot match with tnew>0 SHALL NOT forward; the search SHALL fall through to the next priority level.
REQ-026 The outputs are a don't-care while stall=1; the consuming stage ignores them.
REQ-027 stall_cnt SHALL increment by 1 on each edge with stall=1.
REQ-028 stall_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-029 d_rs==d_rt SHALL be resolved independently per source, producing identical selects.
REQ-030 The same register in both E and M SHALL resolve to E, the youngest producer, when E.tnew==0; if E.tnew>tuse the block SHALL stall, even if M holds a ready value.
REQ-031 d_dst==0 entering E SHALL be recorded as dst 0 and SHALL never match or forward.

Reset
REQ-032 While reset_n=0, all slots SHALL be {0,0} and stall_cnt SHALL be 0, taking effect immediately without a clock edge.
REQ-033 While reset_n=0, stall SHALL be 0, fwd_rs and fwd_rt SHALL be 0, and cmp1 and cmp2 SHALL equal the RF values, or 0 for index 0.
REQ-034 A reset asserted mid-stall SHALL clear the stall in the same cycle and discard all pending slots.
REQ-035 After reset_n deasserts, the first clock edge SHALL perform a normal update.

Verification
REQ-036 Load-use: lw $5 (dst=5, tnew=2) enters E, then beq $5,$0 (tuse 0).
- Required: stall=1 for 2 cycles; then fwd_rs=1 (W) with cmp1=w_data; stall_cnt=2.
REQ-037 ALU result: addu $3 (tnew=1) enters E, then beq $3,$3.
- Required: stall=1 for 1 cycle.
- Then fwd_rs=fwd_rt=2 and cmp1=cmp2=m_data=32'h0000_00AB.
REQ-038 Register zero: E.dst=0 with tnew=0, and beq $0,$0.
- Required: stall=0, fwd_rs=fwd_rt=0, cmp1=cmp2=32'h0.
REQ-039 Priority: E={7,0} and M={7,0}, e_data=32'h1, m_data=32'h2, and rs=7.
- Required: fwd_rs=3 and cmp1=32'h1.
REQ-040 Saturation: CNT_W=2 with 5 consecutive stall cycles.
- Required: stall_cnt sequence 1,2,3,3,3.
REQ-041 Reset during stall: pull reset_n low asynchronously while stall=1 mid-cycle.
- Required: stall=0 and stall_cnt=0 before the next edge; all slots cleared.
